// File: rtl/hazard_pkg.sv
// Shared types and constants for the ID/EX issue controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_BUSY,
    MD_DONE
  } md_state_t;

  typedef logic [4:0] reg_idx_t;

  localparam reg_idx_t ZERO_REG = 5'd0;

endpackage

// File: rtl/muldiv_seq.sv
// Mul/div occupancy sequencer: a start pulse launches a fixed-latency
// operation whose result-ready pulse lands MULDIV_LAT-1 cycles after start.
//
// state   | meaning
// MD_IDLE | unit free, waiting for start
// MD_BUSY | operation in flight, down-counter running
// MD_DONE | one-cycle result-ready pulse, unit still occupied
module muldiv_seq
  import hazard_pkg::*;
#(
  parameter int MULDIV_LAT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy,
  output logic done
);

  localparam int CW = $clog2(MULDIV_LAT + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(MULDIV_LAT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  md_state_t       state_q, state_d;
  logic [CW-1:0]   count_q, count_d;

  // State and down-counter registers; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MD_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Next state and outputs; DONE is entered on the cycle the count reaches one.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      MD_IDLE: begin
        if (start) begin
          count_d = CNT_INIT;
          state_d = (CNT_INIT == CNT_ONE) ? MD_DONE : MD_BUSY;
        end
      end
      MD_BUSY: begin
        busy    = 1'b1;
        count_d = count_q - CNT_ONE;
        if (count_d == CNT_ONE) state_d = MD_DONE;
      end
      MD_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        count_d = '0;
        state_d = MD_IDLE;
      end
      default: begin
        state_d = MD_IDLE;
        count_d = '0;
      end
    endcase
  end

endmodule

// File: rtl/hazard_scoreboard_ctrl.sv
// ID->EX issue controller: per-register pending-write scoreboard, RAW/WAW
// and mul/div structural hazard detection, and a saturating stall counter.
// Build option FORWARD_EN: with EX/MEM forwarding only long-latency
// producers (loads, mul/div) cause data hazards.
module hazard_scoreboard_ctrl
  import hazard_pkg::*;
#(
  parameter int NREGS      = 32,
  parameter int MULDIV_LAT = 4,
  parameter int PERF_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [4:0]        id_rs1reg,
  input  logic [4:0]        id_rs2reg,
  input  logic [4:0]        id_rd,
  input  logic              id_rd_we,
  input  logic              id_is_long,
  input  logic              id_is_muldiv,
  input  logic              ex_stall,
  input  logic              wb_valid,
  input  logic [4:0]        wb_rd,
  output logic              issue,
  output logic              id_stall,
  output logic              md_start,
  output logic              md_busy,
  output logic              md_done,
  output logic [NREGS-1:0]  pending,
  output logic [PERF_W-1:0] stall_cnt
);

  logic [NREGS-1:0]  pend_q, pend_d;
  logic [NREGS-1:0]  wb_clr, set_vec, eff, hz;
  logic [PERF_W-1:0] stall_q, stall_d;
  logic              raw, waw, strct;

  // Writeback clears are visible the same cycle because the regfile is write-through.
  always_comb begin
    wb_clr = '0;
    if (wb_valid && wb_rd != ZERO_REG) wb_clr[wb_rd] = 1'b1;
  end

  assign eff = pend_q & ~wb_clr;

`ifdef FORWARD_EN
  logic [NREGS-1:0] long_q, long_d;

  assign hz     = eff & long_q;
  assign long_d = (long_q & ~wb_clr & ~set_vec) | (set_vec & {NREGS{id_is_long}});

  // Long-latency tag tracks the pending bit it shadows.
  always_ff @(posedge clk) begin
    if (reset) long_q <= '0;
    else       long_q <= long_d;
  end
`else
  logic unused_is_long;

  assign hz             = eff;
  assign unused_is_long = id_is_long;
`endif

  assign raw   = (id_rs1reg != ZERO_REG && hz[id_rs1reg]) ||
                 (id_rs2reg != ZERO_REG && hz[id_rs2reg]);
  assign waw   = id_rd_we && id_rd != ZERO_REG && hz[id_rd];
  assign strct = id_is_muldiv && md_busy;

  assign issue    = id_valid && !ex_stall && !raw && !waw && !strct;
  assign id_stall = ex_stall || (id_valid && !issue);
  assign md_start = issue && id_is_muldiv;

  // Destination of an issuing writer; x0 never becomes pending.
  always_comb begin
    set_vec = '0;
    if (issue && id_rd_we && id_rd != ZERO_REG) set_vec[id_rd] = 1'b1;
  end

  // Set beats clear when an issue and a writeback target the same register.
  assign pend_d  = (pend_q & ~wb_clr) | set_vec;
  assign stall_d = (id_stall && stall_q != {PERF_W{1'b1}}) ? stall_q + 1'b1 : stall_q;

  // Scoreboard and stall counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q  <= '0;
      stall_q <= '0;
    end else begin
      pend_q  <= pend_d;
      stall_q <= stall_d;
    end
  end

  assign pending   = pend_q;
  assign stall_cnt = stall_q;

  muldiv_seq #(
    .MULDIV_LAT(MULDIV_LAT)
  ) u_muldiv_seq (
    .clk  (clk),
    .reset(reset),
    .start(md_start),
    .busy (md_busy),
    .done (md_done)
  );

endmodule

// File: tb/tb_hazard_scoreboard_ctrl.sv
// Bench for hazard_scoreboard_ctrl. The reference model holds the scoreboard
// as a bit array, the mul/div unit as "cycles since start", and the stall
// counter as an integer; both FORWARD_EN builds are modelled.
module tb_hazard_scoreboard_ctrl;

  localparam int NREGS = 32;
  localparam int LAT   = 4;
  localparam int PW    = 4;
  localparam int CMAX  = (1 << PW) - 1;

  logic clk = 1'b0;
  logic reset, id_valid, id_rd_we, id_is_long, id_is_muldiv, ex_stall, wb_valid;
  logic [4:0] id_rs1reg, id_rs2reg, id_rd, wb_rd;
  logic issue, id_stall, md_start, md_busy, md_done;
  logic [NREGS-1:0] pending;
  logic [PW-1:0] stall_cnt;

  always #5 clk = ~clk;

  hazard_scoreboard_ctrl #(.NREGS(NREGS), .MULDIV_LAT(LAT), .PERF_W(PW)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1reg(id_rs1reg),
    .id_rs2reg(id_rs2reg), .id_rd(id_rd), .id_rd_we(id_rd_we), .id_is_long(id_is_long),
    .id_is_muldiv(id_is_muldiv), .ex_stall(ex_stall), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .issue(issue), .id_stall(id_stall), .md_start(md_start), .md_busy(md_busy),
    .md_done(md_done), .pending(pending), .stall_cnt(stall_cnt)
  );

  typedef struct {
    bit v; int rs1; int rs2; int rd; bit we; bit lng; bit md; bit exs; bit wbv; int wbrd; bit rst;
  } stim_t;

  int n_checks = 0;
  int n_fail   = 0;

  bit m_pend[NREGS];
  bit m_long[NREGS];
  int m_age;
  int m_cnt;
  bit e_issue, e_stall, e_start, e_busy, e_done;
  logic [NREGS-1:0] e_pend;
  logic [PW-1:0] e_cnt;

  function automatic stim_t mk(bit v, int rs1, int rs2, int rd, bit we, bit lng, bit md,
                               bit exs, bit wbv, int wbrd, bit rst);
    stim_t s;
    s.v = v; s.rs1 = rs1; s.rs2 = rs2; s.rd = rd; s.we = we; s.lng = lng; s.md = md;
    s.exs = exs; s.wbv = wbv; s.wbrd = wbrd; s.rst = rst;
    return s;
  endfunction

  task automatic drive(stim_t s);
    reset = s.rst; id_valid = s.v; id_rs1reg = 5'(s.rs1); id_rs2reg = 5'(s.rs2);
    id_rd = 5'(s.rd); id_rd_we = s.we; id_is_long = s.lng; id_is_muldiv = s.md;
    ex_stall = s.exs; wb_valid = s.wbv; wb_rd = 5'(s.wbrd);
  endtask

  // A register is a hazard if it has an outstanding writer not retiring right now.
  function automatic bit hazard(int r);
    bit h = m_pend[r] && !(wb_valid && int'(wb_rd) == r);
`ifdef FORWARD_EN
    h = h && m_long[r];
`endif
    return h;
  endfunction

  function automatic void eval_model();
    bit raw, waw, strct;
    raw   = (id_rs1reg != 0 && hazard(int'(id_rs1reg))) || (id_rs2reg != 0 && hazard(int'(id_rs2reg)));
    waw   = id_rd_we && id_rd != 0 && hazard(int'(id_rd));
    strct = id_is_muldiv && m_age >= 1;
    e_issue = id_valid && !ex_stall && !raw && !waw && !strct;
    e_stall = ex_stall || (id_valid && !e_issue);
    e_start = e_issue && id_is_muldiv;
    e_busy  = m_age >= 1;
    e_done  = m_age == LAT - 1;
    for (int r = 0; r < NREGS; r++) e_pend[r] = m_pend[r];
    e_cnt = PW'(m_cnt);
  endfunction

  function automatic void commit();
    if (reset) begin
      for (int r = 0; r < NREGS; r++) begin m_pend[r] = 0; m_long[r] = 0; end
      m_age = -1;
      m_cnt = 0;
      return;
    end
    if (wb_valid && wb_rd != 0) begin m_pend[wb_rd] = 0; m_long[wb_rd] = 0; end
    if (e_issue && id_rd_we && id_rd != 0) begin m_pend[id_rd] = 1; m_long[id_rd] = id_is_long; end
    if (e_stall && m_cnt < CMAX) m_cnt++;
    if (m_age == LAT - 1) m_age = -1;
    else if (m_age >= 1) m_age++;
    else if (e_start) m_age = 1;
  endfunction

  task automatic do_reset();
    drive(mk(0,0,0,0,0,0,0,0,0,0,1));
    #1; eval_model(); commit();
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive(mk(0,0,0,0,0,0,0,0,0,0,1));
    @(negedge clk);
    do_reset();
    drive(mk(0,0,0,0,0,0,0,0,0,0,0));
    #1;
    n_checks++;
    if ({issue, id_stall, md_start, md_busy, md_done} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctl: got %b want 00000", {issue, id_stall, md_start, md_busy, md_done});
    end
    n_checks++;
    if (pending !== '0) begin n_fail++; $display("FAIL reset_pending: got %h want 0", pending); end
    n_checks++;
    if (stall_cnt !== '0) begin n_fail++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); end
    eval_model(); commit();
    @(negedge clk);
  endtask

  task automatic test_raw();
    stim_t t[$];
    do_reset();
    t.push_back(mk(1,0,0,5,1,0,0,0,0,0,0));
    t.push_back(mk(1,5,0,6,0,0,0,0,0,0,0));
    t.push_back(mk(1,5,0,6,0,0,0,0,1,5,0));
    t.push_back(mk(0,0,0,0,0,0,0,0,0,0,0));
    foreach (t[i]) begin
      drive(t[i]); #1; eval_model();
      n_checks++;
      if ({issue, id_stall, md_start, md_busy, md_done} !== {e_issue, e_stall, e_start, e_busy, e_done}) begin
        n_fail++; $display("FAIL raw_ctl[%0d]: got %b want %b", i, {issue, id_stall, md_start, md_busy, md_done}, {e_issue, e_stall, e_start, e_busy, e_done});
      end
      n_checks++;
      if (pending !== e_pend) begin n_fail++; $display("FAIL raw_pending[%0d]: got %h want %h", i, pending, e_pend); end
      n_checks++;
      if (stall_cnt !== e_cnt) begin n_fail++; $display("FAIL raw_stall_cnt[%0d]: got %0d want %0d", i, stall_cnt, e_cnt); end
      commit(); @(negedge clk);
    end
  endtask

  task automatic test_x0();
    stim_t t[$];
    do_reset();
    t.push_back(mk(1,0,0,0,1,1,0,0,0,0,0));
    t.push_back(mk(1,0,0,0,1,0,0,0,0,0,0));
    t.push_back(mk(0,0,0,0,0,0,0,0,1,0,0));
    foreach (t[i]) begin
      drive(t[i]); #1; eval_model();
      n_checks++;
      if (id_stall !== 1'b0) begin n_fail++; $display("FAIL x0_stall[%0d]: got %b want 0", i, id_stall); end
      n_checks++;
      if ({issue, id_stall, md_start, md_busy, md_done} !== {e_issue, e_stall, e_start, e_busy, e_done}) begin
        n_fail++; $display("FAIL x0_ctl[%0d]: got %b want %b", i, {issue, id_stall, md_start, md_busy, md_done}, {e_issue, e_stall, e_start, e_busy, e_done});
      end
      commit(); @(negedge clk);
    end
    n_checks++;
    if (pending !== '0) begin n_fail++; $display("FAIL x0_pending: got %h want 0", pending); end
  endtask

  task automatic test_muldiv();
    stim_t t[$];
    do_reset();
    t.push_back(mk(1,0,0,0,0,0,1,0,0,0,0));
    for (int k = 0; k < 4; k++) t.push_back(mk(1,0,0,0,0,0,1,0,0,0,0));
    for (int k = 0; k < 4; k++) t.push_back(mk(0,0,0,0,0,0,0,0,0,0,0));
    foreach (t[i]) begin
      drive(t[i]); #1; eval_model();
      n_checks++;
      if ({issue, id_stall, md_start, md_busy, md_done} !== {e_issue, e_stall, e_start, e_busy, e_done}) begin
        n_fail++; $display("FAIL muldiv_ctl[%0d]: got %b want %b", i, {issue, id_stall, md_start, md_busy, md_done}, {e_issue, e_stall, e_start, e_busy, e_done});
      end
      n_checks++;
      if (stall_cnt !== e_cnt) begin n_fail++; $display("FAIL muldiv_stall_cnt[%0d]: got %0d want %0d", i, stall_cnt, e_cnt); end
      commit(); @(negedge clk);
    end
    n_checks++;
    if (stall_cnt !== PW'(3)) begin n_fail++; $display("FAIL muldiv_total_stalls: got %0d want 3", stall_cnt); end
  endtask

  task automatic test_collision();
    stim_t t[$];
    do_reset();
    t.push_back(mk(1,0,0,7,1,0,0,0,0,0,0));
    t.push_back(mk(1,0,0,7,1,0,0,0,1,7,0));
    t.push_back(mk(0,0,0,0,0,0,0,0,0,0,0));
    foreach (t[i]) begin
      drive(t[i]); #1; eval_model();
      n_checks++;
      if ({issue, id_stall, md_start, md_busy, md_done} !== {e_issue, e_stall, e_start, e_busy, e_done}) begin
        n_fail++; $display("FAIL collide_ctl[%0d]: got %b want %b", i, {issue, id_stall, md_start, md_busy, md_done}, {e_issue, e_stall, e_start, e_busy, e_done});
      end
      n_checks++;
      if (pending !== e_pend) begin n_fail++; $display("FAIL collide_pending[%0d]: got %h want %h", i, pending, e_pend); end
      commit(); @(negedge clk);
    end
    n_checks++;
    if (pending[7] !== 1'b1) begin n_fail++; $display("FAIL collide_x7: got %b want 1", pending[7]); end
  endtask

  task automatic test_ex_stall();
    stim_t t[$];
    do_reset();
    t.push_back(mk(1,0,0,2,1,0,0,0,0,0,0));
    for (int k = 0; k < CMAX + 3; k++) t.push_back(mk(1,1,4,3,1,0,0,1,0,0,0));
    foreach (t[i]) begin
      drive(t[i]); #1; eval_model();
      n_checks++;
      if ({issue, id_stall, md_start, md_busy, md_done} !== {e_issue, e_stall, e_start, e_busy, e_done}) begin
        n_fail++; $display("FAIL exstall_ctl[%0d]: got %b want %b", i, {issue, id_stall, md_start, md_busy, md_done}, {e_issue, e_stall, e_start, e_busy, e_done});
      end
      n_checks++;
      if (pending !== e_pend) begin n_fail++; $display("FAIL exstall_pending[%0d]: got %h want %h", i, pending, e_pend); end
      n_checks++;
      if (stall_cnt !== e_cnt) begin n_fail++; $display("FAIL exstall_cnt[%0d]: got %0d want %0d", i, stall_cnt, e_cnt); end
      commit(); @(negedge clk);
    end
    n_checks++;
    if (stall_cnt !== {PW{1'b1}}) begin n_fail++; $display("FAIL exstall_saturate: got %0d want %0d", stall_cnt, CMAX); end
  endtask

  task automatic test_forward();
    stim_t t[$];
    do_reset();
    t.push_back(mk(1,0,0,3,1,0,0,0,0,0,0));
    t.push_back(mk(1,0,3,4,1,0,0,0,0,0,0));
    t.push_back(mk(0,0,0,0,0,0,0,0,1,3,0));
    t.push_back(mk(0,0,0,0,0,0,0,0,1,4,0));
    t.push_back(mk(1,0,0,3,1,1,0,0,0,0,0));
    t.push_back(mk(1,0,3,0,0,0,0,0,0,0,0));
    t.push_back(mk(1,0,3,0,0,0,0,0,0,0,0));
    t.push_back(mk(1,0,3,0,0,0,0,0,1,3,0));
    t.push_back(mk(0,0,0,0,0,0,0,0,0,0,0));
    foreach (t[i]) begin
      drive(t[i]); #1; eval_model();
      n_checks++;
      if ({issue, id_stall, md_start, md_busy, md_done} !== {e_issue, e_stall, e_start, e_busy, e_done}) begin
        n_fail++; $display("FAIL fwd_ctl[%0d]: got %b want %b", i, {issue, id_stall, md_start, md_busy, md_done}, {e_issue, e_stall, e_start, e_busy, e_done});
      end
      n_checks++;
      if (pending !== e_pend) begin n_fail++; $display("FAIL fwd_pending[%0d]: got %h want %h", i, pending, e_pend); end
      commit(); @(negedge clk);
    end
  endtask

  task automatic test_reset_busy();
    stim_t t[$];
    do_reset();
    t.push_back(mk(1,0,0,9,1,1,1,0,0,0,0));
    t.push_back(mk(0,0,0,0,0,0,0,0,0,0,1));
    for (int k = 0; k < 4; k++) t.push_back(mk(0,0,0,0,0,0,0,0,0,0,0));
    foreach (t[i]) begin
      drive(t[i]); #1; eval_model();
      n_checks++;
      if ({issue, id_stall, md_start, md_busy, md_done} !== {e_issue, e_stall, e_start, e_busy, e_done}) begin
        n_fail++; $display("FAIL rstbusy_ctl[%0d]: got %b want %b", i, {issue, id_stall, md_start, md_busy, md_done}, {e_issue, e_stall, e_start, e_busy, e_done});
      end
      n_checks++;
      if (pending !== e_pend) begin n_fail++; $display("FAIL rstbusy_pending[%0d]: got %h want %h", i, pending, e_pend); end
      if (i >= 2) begin
        n_checks++;
        if (md_done !== 1'b0) begin n_fail++; $display("FAIL rstbusy_no_done[%0d]: got %b want 0", i, md_done); end
      end
      commit(); @(negedge clk);
    end
  endtask

  task automatic test_random();
    stim_t s;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      s = mk(($urandom % 4) != 0, $urandom % 8, $urandom % 8, $urandom % 8,
             ($urandom % 10) < 7, ($urandom % 10) < 3, ($urandom % 5) == 0,
             ($urandom % 7) == 0, ($urandom % 5) < 2, $urandom % 8, ($urandom % 100) == 0);
      drive(s); #1; eval_model();
      n_checks++;
      if ({issue, id_stall, md_start, md_busy, md_done} !== {e_issue, e_stall, e_start, e_busy, e_done}) begin
        n_fail++; $display("FAIL rand_ctl[%0d]: got %b want %b", i, {issue, id_stall, md_start, md_busy, md_done}, {e_issue, e_stall, e_start, e_busy, e_done});
      end
      n_checks++;
      if (pending !== e_pend) begin n_fail++; $display("FAIL rand_pending[%0d]: got %h want %h", i, pending, e_pend); end
      n_checks++;
      if (stall_cnt !== e_cnt) begin n_fail++; $display("FAIL rand_stall_cnt[%0d]: got %0d want %0d", i, stall_cnt, e_cnt); end
      commit(); @(negedge clk);
    end
  endtask

  initial begin
    drive(mk(0,0,0,0,0,0,0,0,0,0,1));
    @(negedge clk);
    test_reset();
    test_raw();
    test_x0();
    test_muldiv();
    test_collision();
    test_ex_stall();
    test_forward();
    test_reset_busy();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard_ctrl.md
Name: hazard_scoreboard_ctrl

Overview:
Issue controller between the decode (ID) and execute (EX) stages of the RV64 pipeline. Keeps a per-register pending-write scoreboard and sequences the multi-cycle mul/div unit. Decides each cycle whether the decoded instruction issues to EX or holds ID/IF with a stall. Replaces the pass-through of the EX stall to the IDIF stall.

Parameters:
NREGS, 32, number of architectural GPRs (x0 hardwired zero)
MULDIV_LAT, 4, mul/div execute latency in cycles (>=2)
PERF_W, 32, width of the saturating stall counter

Ports:
clk  in  1  pipeline clock
reset  in  1  synchronous, active-high reset
id_valid  in  1  ID holds a decoded instruction
id_rs1reg  in  5  source register 1 index (0 = unused)
id_rs2reg  in  5  source register 2 index (0 = unused)
id_rd  in  5  destination register index
id_rd_we  in  1  instruction writes rd
id_is_long  in  1  load or mul/div (result not available from EX)
id_is_muldiv  in  1  instruction uses the mul/div unit
ex_stall  in  1  EX cannot accept an instruction this cycle
wb_valid  in  1  writeback retiring a register write
wb_rd  in  5  writeback destination
issue  out  1  ID advances to EX this cycle
id_stall  out  1  hold IF/ID registers
md_start  out  1  one-cycle start pulse to the mul/div unit
md_busy  out  1  mul/div unit occupied
md_done  out  1  one-cycle result-ready pulse
pending  out  NREGS  scoreboard bit vector
stall_cnt  out  PERF_W  saturating count of id_stall cycles

Behaviour:
- Reset, synchronous and active-high, clears the following on the next edge: pending=0, stall_cnt=0, FSM=IDLE, count=0. issue, md_start, md_busy, md_done and id_stall are then 0. Reset mid-mul/div aborts the operation with no md_done.
- Effective pending: eff[r] = pending[r] & ~(wb_valid & wb_rd==r). The regfile is write-through, so a writeback resolves a hazard in the same cycle.
- raw = (rs1!=0 & eff[rs1]) | (rs2!=0 & eff[rs2]).
- waw = id_rd_we & id_rd!=0 & eff[id_rd]. Only one outstanding writer per register is allowed.
- struct = id_is_muldiv & (FSM!=IDLE).
- issue = id_valid & ~ex_stall & ~raw & ~waw & ~struct. This is combinational.
- id_stall = ex_stall | (id_valid & ~issue).
- Scoreboard update at the edge:
  - An issue with id_rd_we & id_rd!=0 sets pending[id_rd].
  - wb_valid clears pending[wb_rd].
  - If set and clear hit the same register in the same cycle, set wins.
  - pending[0] is never set.
- Long tracking: a parallel long[] vector is set alongside pending when id_is_long and cleared with pending. It is used only by the optional feature.
- Mul/div FSM:
  - IDLE: on issue & id_is_muldiv, md_start=1 in that cycle, count<=MULDIV_LAT-1, go to BUSY.
  - BUSY: md_busy=1, count decrements each cycle; when count==1, go to DONE.
  - DONE: md_done=1 and md_busy=1 for one cycle, then IDLE.
  - A new mul/div cannot issue in DONE. It issues the cycle after DONE.
  - ex_stall does not pause the FSM.
- stall_cnt increments each cycle id_stall=1 and saturates at all-ones.
- A writeback to a register that is not pending is harmless (clear of 0). wb_rd=0 is ignored.

Optional Feature:
Macro FORWARD_EN.
- Defined: EX/MEM forwarding exists. raw and waw use eff & long instead of eff, so only long-latency producers stall.
- Undefined: any pending producer stalls, and the long vector is optimised away.

Decomposition:
- Package hazard_pkg holds:
  - typedef md_state_t {MD_IDLE, MD_BUSY, MD_DONE}
  - typedef reg_idx_t (logic [4:0])
  - constant ZERO_REG=0
- One natural sub-module is muldiv_seq: the FSM plus down-counter, with ports start, busy, done.
- The scoreboard and issue logic stay in the top module.

Test Plan:
1. RAW stall: issue addi x5 (rd_we). Next cycle id_rs1reg=5 with no wb -> issue=0, id_stall=1. Assert wb_valid, wb_rd=5 -> issue=1 in that same cycle.
2. x0 immunity: rd=0 issue followed by rs1=0 -> pending stays 0 and there is no stall.
3. Mul/div sequencing, MULDIV_LAT=4: muldiv issue at cycle t -> md_start at t. md_busy over t+1..t+3, md_done at t+3. A second muldiv presented at t+1 issues at t+4. stall_cnt=3.
4. Set/clear collision: pending[7]=1, and in the same cycle wb_rd=7 plus an issue with id_rd=7 -> issue=1 (WAW resolved by write-through), pending[7]=1 afterwards.
5. ex_stall with no hazards -> issue=0, id_stall=1, scoreboard unchanged. stall_cnt preset to all-ones stays all-ones.
6. FORWARD_EN: non-long writer x3 followed by rs2=3 -> issues with no stall. Load writer x3 -> stalls until wb_rd=3. Without the macro, both cases stall. Reset asserted in BUSY -> next cycle IDLE, no md_done, pending=0.
